// File: rtl/data_mem_controller.sv
// data_mem_controller
// Arbitrates per-thread LSU load/store requests onto NUM_CHANNELS data-memory
// ports. Each channel runs its own FSM and owns at most one consumer; a busy
// mask keeps a consumer from being held by two channels at once. Read data
// and write completions are relayed back until the LSU drops its valid.
//
// Configuration macro: DATA_MEM_RR_ARB_EN
//   defined   - round-robin arbitration with a rotating search pointer
//   undefined - fixed priority, lowest free consumer index wins
//
// Ports
//   clk, reset               clock (posedge), synchronous active-high reset
//   consumer_read_*          per-LSU load handshake (valid/address in, ready/data out)
//   consumer_write_*         per-LSU store handshake (valid/address/data in, ready out)
//   mem_read_*               per-channel load handshake to data memory
//   mem_write_*              per-channel store handshake to data memory
module data_mem_controller #(
    parameter int unsigned NUM_CONSUMERS = 8,
    parameter int unsigned NUM_CHANNELS  = 2,
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

    localparam int unsigned CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_READ_WAITING   = 3'd1,
        ST_WRITE_WAITING  = 3'd2,
        ST_READ_RELAYING  = 3'd3,
        ST_WRITE_RELAYING = 3'd4
    } state_t;

    state_t        state_q [NUM_CHANNELS];
    state_t        state_d [NUM_CHANNELS];
    logic [CW-1:0] owner_q [NUM_CHANNELS];
    logic [CW-1:0] owner_d [NUM_CHANNELS];

    logic [NUM_CONSUMERS-1:0] busy_q;
    logic [NUM_CONSUMERS-1:0] busy_d;
    logic [NUM_CONSUMERS-1:0] claimed;
    logic                     found;
    logic [CW-1:0]            pick;

    logic [NUM_CONSUMERS-1:0]                consumer_read_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_d;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready_d;
    logic [NUM_CHANNELS-1:0]                 mem_read_valid_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address_d;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data_d;

`ifdef DATA_MEM_RR_ARB_EN
    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;
    logic [CW-1:0] cand;
`endif

    // Next-state and next-output logic; channels evaluated in index order so
    // a consumer claimed by a lower channel is invisible to higher ones.
    always_comb begin
        state_d                = state_q;
        owner_d                = owner_q;
        busy_d                 = busy_q;
        claimed                = busy_q;
        found                  = 1'b0;
        pick                   = '0;
        consumer_read_ready_d  = consumer_read_ready;
        consumer_read_data_d   = consumer_read_data;
        consumer_write_ready_d = consumer_write_ready;
        mem_read_valid_d       = mem_read_valid;
        mem_read_address_d     = mem_read_address;
        mem_write_valid_d      = mem_write_valid;
        mem_write_address_d    = mem_write_address;
        mem_write_data_d       = mem_write_data;
`ifdef DATA_MEM_RR_ARB_EN
        ptr_d = ptr_q;
        cand  = '0;
`endif

        for (int c = 0; c < NUM_CHANNELS; c++) begin
            found = 1'b0;
            pick  = '0;
            case (state_q[c])
                ST_IDLE: begin
`ifdef DATA_MEM_RR_ARB_EN
                    // Search starts at the pointer, which may already have
                    // moved this cycle because of a lower channel's grant.
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        cand = CW'((32'(ptr_d) + 32'(k)) % NUM_CONSUMERS);
                        if (!found && !claimed[cand] &&
                            (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
                            found = 1'b1;
                            pick  = cand;
                        end
                    end
`else
                    // Descending scan so the lowest free index is the last winner.
                    for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
                        if (!claimed[i] && (consumer_read_valid[i] || consumer_write_valid[i])) begin
                            found = 1'b1;
                            pick  = CW'(i);
                        end
                    end
`endif
                    if (found) begin
                        claimed[pick] = 1'b1;
                        busy_d[pick]  = 1'b1;
                        owner_d[c]    = pick;
`ifdef DATA_MEM_RR_ARB_EN
                        ptr_d = (32'(pick) == NUM_CONSUMERS - 1) ? '0 : CW'(pick + 1'b1);
`endif
                        // Read wins when a consumer asserts both.
                        if (consumer_read_valid[pick]) begin
                            mem_read_valid_d[c]   = 1'b1;
                            mem_read_address_d[c] = consumer_read_address[pick];
                            state_d[c]            = ST_READ_WAITING;
                        end else begin
                            mem_write_valid_d[c]   = 1'b1;
                            mem_write_address_d[c] = consumer_write_address[pick];
                            mem_write_data_d[c]    = consumer_write_data[pick];
                            state_d[c]             = ST_WRITE_WAITING;
                        end
                    end
                end

                ST_READ_WAITING: begin
                    if (mem_read_ready[c]) begin
                        mem_read_valid_d[c]                = 1'b0;
                        consumer_read_data_d[owner_q[c]]   = mem_read_data[c];
                        consumer_read_ready_d[owner_q[c]]  = 1'b1;
                        state_d[c]                         = ST_READ_RELAYING;
                    end
                end

                ST_WRITE_WAITING: begin
                    if (mem_write_ready[c]) begin
                        mem_write_valid_d[c]               = 1'b0;
                        consumer_write_ready_d[owner_q[c]] = 1'b1;
                        state_d[c]                         = ST_WRITE_RELAYING;
                    end
                end

                ST_READ_RELAYING: begin
                    if (!consumer_read_valid[owner_q[c]]) begin
                        consumer_read_ready_d[owner_q[c]] = 1'b0;
                        busy_d[owner_q[c]]                = 1'b0;
                        mem_read_address_d[c]             = '0;
                        state_d[c]                        = ST_IDLE;
                    end
                end

                ST_WRITE_RELAYING: begin
                    if (!consumer_write_valid[owner_q[c]]) begin
                        consumer_write_ready_d[owner_q[c]] = 1'b0;
                        busy_d[owner_q[c]]                 = 1'b0;
                        mem_write_address_d[c]             = '0;
                        mem_write_data_d[c]                = '0;
                        state_d[c]                         = ST_IDLE;
                    end
                end

                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= ST_IDLE;
                owner_q[c] <= '0;
            end
            busy_q               <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_read_address     <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
`ifdef DATA_MEM_RR_ARB_EN
            ptr_q <= '0;
`endif
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                owner_q[c] <= owner_d[c];
            end
            busy_q               <= busy_d;
            consumer_read_ready  <= consumer_read_ready_d;
            consumer_read_data   <= consumer_read_data_d;
            consumer_write_ready <= consumer_write_ready_d;
            mem_read_valid       <= mem_read_valid_d;
            mem_read_address     <= mem_read_address_d;
            mem_write_valid      <= mem_write_valid_d;
            mem_write_address    <= mem_write_address_d;
            mem_write_data       <= mem_write_data_d;
`ifdef DATA_MEM_RR_ARB_EN
            ptr_q <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// Testbench for data_mem_controller: cycle-by-cycle vector table for the
// load/store/contention/reset sequences, then a hand-driven arbitration run
// with all eight LSUs requesting repeatedly.
module tb_data_mem_controller;

    localparam int unsigned NC = 8;
    localparam int unsigned CH = 2;
    localparam int unsigned AB = 8;
    localparam int unsigned DB = 32;
    localparam int unsigned NVEC = 32;
    localparam int unsigned NGRANT = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NC-1:0]            consumer_read_valid;
    logic [NC-1:0][AB-1:0]    consumer_read_address;
    logic [NC-1:0]            consumer_read_ready;
    logic [NC-1:0][DB-1:0]    consumer_read_data;
    logic [NC-1:0]            consumer_write_valid;
    logic [NC-1:0][AB-1:0]    consumer_write_address;
    logic [NC-1:0][DB-1:0]    consumer_write_data;
    logic [NC-1:0]            consumer_write_ready;
    logic [CH-1:0]            mem_read_valid;
    logic [CH-1:0][AB-1:0]    mem_read_address;
    logic [CH-1:0]            mem_read_ready;
    logic [CH-1:0][DB-1:0]    mem_read_data;
    logic [CH-1:0]            mem_write_valid;
    logic [CH-1:0][AB-1:0]    mem_write_address;
    logic [CH-1:0][DB-1:0]    mem_write_data;
    logic [CH-1:0]            mem_write_ready;

    data_mem_controller #(
        .NUM_CONSUMERS(NC),
        .NUM_CHANNELS (CH),
        .ADDR_BITS    (AB),
        .DATA_BITS    (DB)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (consumer_read_valid),
        .consumer_read_address (consumer_read_address),
        .consumer_read_ready   (consumer_read_ready),
        .consumer_read_data    (consumer_read_data),
        .consumer_write_valid  (consumer_write_valid),
        .consumer_write_address(consumer_write_address),
        .consumer_write_data   (consumer_write_data),
        .consumer_write_ready  (consumer_write_ready),
        .mem_read_valid        (mem_read_valid),
        .mem_read_address      (mem_read_address),
        .mem_read_ready        (mem_read_ready),
        .mem_read_data         (mem_read_data),
        .mem_write_valid       (mem_write_valid),
        .mem_write_address     (mem_write_address),
        .mem_write_data        (mem_write_data),
        .mem_write_ready       (mem_write_ready)
    );

    always #5 clk = ~clk;

    // One clock of stimulus and the outputs expected right after that edge.
    typedef struct {
        logic          rst;
        logic [7:0]    rv;
        logic [7:0]    wv;
        logic [1:0]    mrr;
        logic [1:0]    mwr;
        logic [31:0]   rdata;
        logic [7:0]    e_crr;
        logic [7:0]    e_cwr;
        logic [1:0]    e_mrv;
        logic [1:0]    e_mwv;
        logic [7:0]    e_mra0;
        logic [7:0]    e_mra1;
        logic [7:0]    e_mwa0;
        logic [31:0]   e_mwd0;
        int            rd_idx;
        logic [31:0]   e_rd;
    } vec_t;

    vec_t vecs [NVEC];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(
        input logic rst, input logic [7:0] rv, input logic [7:0] wv,
        input logic [1:0] mrr, input logic [1:0] mwr, input logic [31:0] rdata,
        input logic [7:0] e_crr, input logic [7:0] e_cwr,
        input logic [1:0] e_mrv, input logic [1:0] e_mwv,
        input logic [7:0] e_mra0, input logic [7:0] e_mra1,
        input logic [7:0] e_mwa0, input logic [31:0] e_mwd0,
        input int rd_idx, input logic [31:0] e_rd);
        vec_t v;
        v.rst = rst;  v.rv = rv;  v.wv = wv;  v.mrr = mrr;  v.mwr = mwr;  v.rdata = rdata;
        v.e_crr = e_crr;  v.e_cwr = e_cwr;  v.e_mrv = e_mrv;  v.e_mwv = e_mwv;
        v.e_mra0 = e_mra0;  v.e_mra1 = e_mra1;  v.e_mwa0 = e_mwa0;  v.e_mwd0 = e_mwd0;
        v.rd_idx = rd_idx;  v.e_rd = e_rd;
        return v;
    endfunction

    task automatic check(input string name, input int tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [7:0] a);
        return (a == 8'h10) ? 3 : int'(a) - 'h40;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int        ngrant;
        int        exp_g;
        int        got_g;
        logic [1:0] prev_mrv;

        // Fixed per-LSU addresses/data; LSU3 loads 0x10, LSU0 stores 7 to 0x22.
        for (int i = 0; i < NC; i++) begin
            consumer_read_address[i]  = (i == 3) ? 8'h10 : 8'(8'h40 + i);
            consumer_write_address[i] = (i == 0) ? 8'h22 : 8'(8'h60 + i);
            consumer_write_data[i]    = (i == 0) ? 32'd7 : 32'(32'h100 + i);
        end
        reset = 1'b1;
        consumer_read_valid  = '0;
        consumer_write_valid = '0;
        mem_read_ready       = '0;
        mem_write_ready      = '0;
        mem_read_data        = '0;

        //                 rst   rv     wv     mrr    mwr    rdata          crr    cwr    mrv    mwv    mra0   mra1   mwa0   mwd0     idx rd
        // reset and idle
        vecs[0]  = mk(1'b1, 8'h00, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 32'h0,   3, 32'h0);
        vecs[1]  = mk(1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 32'h0,   3, 32'h0);
        // single load by LSU3, memory answers on the fourth cycle
        vecs[2]  = mk(1'b0, 8'h08, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 32'h0,   3, 32'h0);
        vecs[3]  = mk(1'b0, 8'h08, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 32'h0,   3, 32'h0);
        vecs[4]  = mk(1'b0, 8'h08, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 32'h0,   3, 32'h0);
        vecs[5]  = mk(1'b0, 8'h08, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 32'h0,   3, 32'h0);
        vecs[6]  = mk(1'b0, 8'h08, 8'h00, 2'b01, 2'b00, 32'hDEADBEEF, 8'h08, 8'h00, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 32'h0,   3, 32'hDEADBEEF);
        vecs[7]  = mk(1'b0, 8'h08, 8'h00, 2'b00, 2'b00, 32'h0,        8'h08, 8'h00, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 32'h0,   3, 32'hDEADBEEF);
        vecs[8]  = mk(1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 32'h0,   3, 32'hDEADBEEF);
        // memory ready while idle is ignored
        vecs[9]  = mk(1'b0, 8'h00, 8'h00, 2'b11, 2'b11, 32'h12345678, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 32'h0,   3, 32'hDEADBEEF);
        // single store by LSU0; write ready during relaying is ignored
        vecs[10] = mk(1'b0, 8'h00, 8'h01, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b00, 2'b01, 8'h00, 8'h00, 8'h22, 32'd7,   3, 32'hDEADBEEF);
        vecs[11] = mk(1'b0, 8'h00, 8'h01, 2'b00, 2'b01, 32'h0,        8'h00, 8'h01, 2'b00, 2'b00, 8'h00, 8'h00, 8'h22, 32'd7,   3, 32'hDEADBEEF);
        vecs[12] = mk(1'b0, 8'h00, 8'h01, 2'b00, 2'b01, 32'h0,        8'h00, 8'h01, 2'b00, 2'b00, 8'h00, 8'h00, 8'h22, 32'd7,   3, 32'hDEADBEEF);
        vecs[13] = mk(1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 32'h0,   3, 32'hDEADBEEF);
        // reset clears read data and the arbitration pointer
        vecs[14] = mk(1'b1, 8'h00, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 32'h0,   3, 32'h0);
        // contention: LSUs 0,1,2 read; 2 waits for a channel to go idle
        vecs[15] = mk(1'b0, 8'h07, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b11, 2'b00, 8'h40, 8'h41, 8'h00, 32'h0,   1, 32'h0);
        vecs[16] = mk(1'b0, 8'h07, 8'h00, 2'b10, 2'b00, 32'hA1A1A1A1, 8'h02, 8'h00, 2'b01, 2'b00, 8'h40, 8'h41, 8'h00, 32'h0,   1, 32'hA1A1A1A1);
        vecs[17] = mk(1'b0, 8'h05, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b01, 2'b00, 8'h40, 8'h00, 8'h00, 32'h0,   1, 32'hA1A1A1A1);
        vecs[18] = mk(1'b0, 8'h05, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b11, 2'b00, 8'h40, 8'h42, 8'h00, 32'h0,   1, 32'hA1A1A1A1);
        vecs[19] = mk(1'b0, 8'h05, 8'h00, 2'b11, 2'b00, 32'hC0C0C0C0, 8'h05, 8'h00, 2'b00, 2'b00, 8'h40, 8'h42, 8'h00, 32'h0,   2, 32'hC0C0C0C0);
        vecs[20] = mk(1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 32'h0,   0, 32'hC0C0C0C0);
        // LSU5 asserts read and write: read first, write on a later grant
        vecs[21] = mk(1'b0, 8'h20, 8'h20, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b01, 2'b00, 8'h45, 8'h00, 8'h00, 32'h0,   5, 32'h0);
        vecs[22] = mk(1'b0, 8'h20, 8'h20, 2'b01, 2'b00, 32'h55AA55AA, 8'h20, 8'h00, 2'b00, 2'b00, 8'h45, 8'h00, 8'h00, 32'h0,   5, 32'h55AA55AA);
        vecs[23] = mk(1'b0, 8'h00, 8'h20, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 32'h0,   5, 32'h55AA55AA);
        vecs[24] = mk(1'b0, 8'h00, 8'h20, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b00, 2'b01, 8'h00, 8'h00, 8'h65, 32'h105, 5, 32'h55AA55AA);
        vecs[25] = mk(1'b0, 8'h00, 8'h20, 2'b00, 2'b01, 32'h0,        8'h00, 8'h20, 2'b00, 2'b00, 8'h00, 8'h00, 8'h65, 32'h105, 5, 32'h55AA55AA);
        vecs[26] = mk(1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 32'h0,   5, 32'h55AA55AA);
        // reset during READ_WAITING, then a fresh load completes
        vecs[27] = mk(1'b0, 8'h08, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 32'h0,   3, 32'h0);
        vecs[28] = mk(1'b1, 8'h08, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 32'h0,   3, 32'h0);
        vecs[29] = mk(1'b0, 8'h08, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 32'h0,   3, 32'h0);
        vecs[30] = mk(1'b0, 8'h08, 8'h00, 2'b01, 2'b00, 32'h0BADF00D, 8'h08, 8'h00, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 32'h0,   3, 32'h0BADF00D);
        vecs[31] = mk(1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 32'h0,        8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 32'h0,   3, 32'h0BADF00D);

        for (int r = 0; r < NVEC; r++) begin
            reset                = vecs[r].rst;
            consumer_read_valid  = vecs[r].rv;
            consumer_write_valid = vecs[r].wv;
            mem_read_ready       = vecs[r].mrr;
            mem_write_ready      = vecs[r].mwr;
            mem_read_data[0]     = vecs[r].rdata;
            mem_read_data[1]     = vecs[r].rdata;
            @(posedge clk);
            #1;
            check("consumer_read_ready",  r, 32'(consumer_read_ready),  32'(vecs[r].e_crr));
            check("consumer_write_ready", r, 32'(consumer_write_ready), 32'(vecs[r].e_cwr));
            check("mem_read_valid",       r, 32'(mem_read_valid),       32'(vecs[r].e_mrv));
            check("mem_write_valid",      r, 32'(mem_write_valid),      32'(vecs[r].e_mwv));
            check("mem_read_address0",    r, 32'(mem_read_address[0]),  32'(vecs[r].e_mra0));
            check("mem_read_address1",    r, 32'(mem_read_address[1]),  32'(vecs[r].e_mra1));
            check("mem_write_address0",   r, 32'(mem_write_address[0]), 32'(vecs[r].e_mwa0));
            check("mem_write_data0",      r, mem_write_data[0],         vecs[r].e_mwd0);
            check("consumer_read_data",   r, consumer_read_data[vecs[r].rd_idx], vecs[r].e_rd);
        end

        // All LSUs request repeatedly; memory answers one cycle after valid,
        // and each LSU drops valid for one cycle after its ready.
        reset                = 1'b1;
        consumer_read_valid  = '0;
        consumer_write_valid = '0;
        mem_read_ready       = '0;
        mem_write_ready      = '0;
        @(posedge clk);
        #1;
        reset               = 1'b0;
        consumer_read_valid = '1;
        prev_mrv            = '0;
        ngrant              = 0;
        for (int cyc = 0; cyc < 200 && ngrant < int'(NGRANT); cyc++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < CH; c++) begin
                if (mem_read_valid[c] && !prev_mrv[c] && ngrant < int'(NGRANT)) begin
                    got_g = idx_of(mem_read_address[c]);
`ifdef DATA_MEM_RR_ARB_EN
                    exp_g = ngrant % 8;
`else
                    exp_g = ngrant % 2;
`endif
                    check("arb_grant", ngrant, 32'(got_g), 32'(exp_g));
                    ngrant++;
                end
            end
            if (&mem_read_valid)
                check("arb_distinct", cyc, 32'(mem_read_address[0] != mem_read_address[1]), 32'd1);
            prev_mrv            = mem_read_valid;
            mem_read_ready      = mem_read_valid;
            mem_read_data[0]    = 32'hA5A5_0000;
            mem_read_data[1]    = 32'hA5A5_0001;
            consumer_read_valid = ~consumer_read_ready;
        end
        check("arb_grant_count", 0, 32'(ngrant), 32'(NGRANT));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
